// File: rtl/int_div_iter_pkg.sv
// Shared definitions for the iterative integer divider: ALU op modes, divider
// FSM state encodings and the fixed result constants used for special cases.
package int_div_iter_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_OP_IDLE    = 3'd0,
    ALU_OP_INT_ADD = 3'd1,
    ALU_OP_INT_SUB = 3'd2,
    ALU_OP_INT_MUL = 3'd3,
    ALU_OP_INT_DIV = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_FIX  = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/int_div_iter_sign_fix.sv
// Converts the unsigned quotient/remainder magnitudes back to signed results:
// the quotient flips when operand signs differ, the remainder follows the dividend.
module int_div_iter_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] quo_mag,
  input  logic [WIDTH-1:0] rem_mag,
  input  logic             neg_q,
  input  logic             neg_r,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  always_comb begin
    quotient  = neg_q ? (~quo_mag + 1'b1) : quo_mag;
    remainder = neg_r ? (~rem_mag + 1'b1) : rem_mag;
  end

endmodule

// File: rtl/int_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle, with RISC-V
// DIV/DIVU/REM/REMU semantics. Responder side of the ALU i_valid/o_valid handshake.
module int_div_iter
  import int_div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output div_state_e       o_dbg_state
);

  // Handshake: the requester raises i_valid with stable operands and holds it
  // until it sees o_valid; o_valid stays high while i_valid stays high, and
  // dropping i_valid before o_valid aborts the operation with no result.

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             is_div_zero;
  logic             is_overflow;

  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic             trial_unused;

  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  always_comb begin
    a_neg       = i_signed & i_a[WIDTH-1];
    b_neg       = i_signed & i_b[WIDTH-1];
    a_mag       = a_neg ? (~i_a + 1'b1) : i_a;
    b_mag       = b_neg ? (~i_b + 1'b1) : i_b;
    is_div_zero = (i_b == '0);
    is_overflow = i_signed && (i_a == MIN_NEG) && (i_b == '1);
  end

  // The dividend is shifted out of quo MSB-first while quotient bits shift in.
  always_comb begin
    partial      = {rem, quo[WIDTH-1]};
    trial        = {1'b0, partial} - {2'b00, divisor};
    borrow       = trial[WIDTH+1];
    trial_unused = trial[WIDTH];
  end

  int_div_iter_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .quo_mag   (quo),
    .rem_mag   (rem),
    .neg_q     (neg_q),
    .neg_r     (neg_r),
    .quotient  (fix_q),
    .remainder (fix_r)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= DIV_ST_IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      case (state)
        DIV_ST_IDLE: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          if (i_valid) begin
            rem     <= '0;
            quo     <= a_mag;
            divisor <= b_mag;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            cnt     <= CNT_LAST;
            if (is_div_zero) begin
              o_quotient  <= DIV_BY_ZERO_Q[WIDTH-1:0];
              o_remainder <= i_a;
              state       <= DIV_ST_DONE;
            end else if (is_overflow) begin
              o_quotient  <= MIN_NEG;
              o_remainder <= '0;
              state       <= DIV_ST_DONE;
            end else begin
              o_busy <= 1'b1;
              state  <= DIV_ST_CALC;
            end
          end
        end
        DIV_ST_CALC: begin
          if (!i_valid) begin
            o_busy <= 1'b0;
            state  <= DIV_ST_IDLE;
          end else begin
            rem <= borrow ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~borrow};
            if (cnt == '0) begin
              state <= DIV_ST_FIX;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DIV_ST_FIX: begin
          o_busy <= 1'b0;
          if (!i_valid) begin
            state <= DIV_ST_IDLE;
          end else begin
            o_quotient  <= fix_q;
            o_remainder <= fix_r;
            state       <= DIV_ST_DONE;
          end
        end
        DIV_ST_DONE: begin
          o_busy <= 1'b0;
          if (i_valid) begin
            o_valid <= 1'b1;
          end else begin
            o_valid <= 1'b0;
            state   <= DIV_ST_IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= DIV_ST_IDLE;
        end
      endcase
    end
  end

  assign o_dbg_state = state;

endmodule

// File: tb/tb_int_div_iter.sv
// Scoreboarded bench for int_div_iter: directed vectors with hand-computed
// results, abort/reset scenarios and a short random run against a reference model.
module tb_int_div_iter;
  import int_div_iter_pkg::*;

  localparam int W = 32;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_valid;
  logic         i_signed;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_valid;
  logic         o_busy;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;
  div_state_e   o_dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*W-1:0] exp_q[$];
  int             due_q[$];
  logic           vld_d = 1'b0;
  logic [W-1:0]   last_q = '0;
  logic [W-1:0]   last_r = '0;

  int_div_iter #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_signed    (i_signed),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    if (b == '0) begin
      q = '1; r = a; lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0; lat = 1;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      lat = W + 2;
    end else begin
      q = a / b; r = a % b; lat = W + 2;
    end
  endfunction

  // monitor: pops the scoreboard on every rising o_valid
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_valid && !vld_d) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          check("result", {o_quotient, o_remainder}, exp_q.pop_front());
          check("latency", 64'(cyc), 64'(due_q.pop_front()));
        end
      end
      vld_d = o_valid;
    end else begin
      vld_d = 1'b0;
    end
  end

  // driver tasks
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge i_clk);
    i_a = a; i_b = b; i_signed = s; i_valid = 1'b1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input int lat,
                       input int hold);
    bit got = 0;
    bit stable = 1;
    int n = 0;
    issue(a, b, s);
    exp_q.push_back({eq, er});
    due_q.push_back(cyc + 1 + lat);
    while (!got && n < 80) begin
      @(negedge i_clk);
      n++;
      if (o_valid) got = 1;
    end
    if (!got) begin
      check("timeout", 64'd0, 64'd1);
      void'(exp_q.pop_back());
      void'(due_q.pop_back());
    end else if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge i_clk);
        if (!o_valid || o_quotient !== eq || o_remainder !== er || o_busy) stable = 0;
      end
      check("hold_stable", 64'(stable), 64'd1);
    end
    last_q = eq; last_r = er;
    i_valid = 1'b0;
    i_a = 'x; i_b = 'x;
  endtask

  initial begin
    logic [W-1:0] rq, rr, ra, rb;
    int rlat;
    logic rs;
    bit seen;

    i_rst_n = 1'b0; i_valid = 1'b0; i_signed = 1'b0; i_a = '0; i_b = '0;
    repeat (3) @(negedge i_clk);
    check("reset_outputs", {30'd0, o_valid, o_busy, o_quotient ^ o_remainder}, 64'd0);
    check("reset_quot", {32'd0, o_quotient}, 64'd0);
    check("reset_state", 64'(o_dbg_state), 64'(DIV_ST_IDLE));
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    do_op(32'd100,        32'd7,        1'b0, 32'd14,         32'd2,          34, 5);
    do_op(32'hFFFF_FFF9,  32'd2,        1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  34, 0);
    do_op(32'd7,          32'hFFFF_FFFE,1'b1, 32'hFFFF_FFFD,  32'd1,          34, 0);
    do_op(32'h1234_5678,  32'd0,        1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1,  0);
    do_op(32'h1234_5678,  32'd0,        1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1,  5);
    do_op(32'h8000_0000,  32'hFFFF_FFFF,1'b1, 32'h8000_0000,  32'd0,          1,  0);
    do_op(32'h8000_0000,  32'hFFFF_FFFF,1'b0, 32'd0,          32'h8000_0000,  34, 0);
    do_op(32'hFFFF_FFF9,  32'hFFFF_FFFE,1'b1, 32'd3,          32'hFFFF_FFFF,  34, 0);
    do_op(32'd0,          32'd5,        1'b0, 32'd0,          32'd0,          34, 0);
    do_op(32'hFFFF_FFFF,  32'd1,        1'b0, 32'hFFFF_FFFF,  32'd0,          34, 0);
    do_op(32'h8000_0000,  32'd1,        1'b1, 32'h8000_0000,  32'd0,          34, 0);
    do_op(32'h8000_0000,  32'd2,        1'b1, 32'hC000_0000,  32'd0,          34, 0);
    do_op(32'd5,          32'd10,       1'b0, 32'd0,          32'd5,          34, 0);
    do_op(32'd0,          32'd0,        1'b1, 32'hFFFF_FFFF,  32'd0,          1,  0);
    do_op(32'd1000,       32'd3,        1'b0, 32'd333,        32'd1,          34, 0);

    // abort at CALC cycle 10
    issue(32'd999, 32'd4, 1'b0);
    repeat (10) @(negedge i_clk);
    check("busy_in_calc", {63'd0, o_busy}, 64'd1);
    i_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge i_clk);
      if (o_valid) seen = 1;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    check("abort_outputs", {o_quotient, o_remainder}, {last_q, last_r});
    check("abort_state", 64'(o_dbg_state), 64'(DIV_ST_IDLE));

    // asynchronous reset mid-CALC
    issue(32'd500, 32'd7, 1'b0);
    repeat (15) @(negedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    check("async_reset", {o_quotient, o_remainder}, 64'd0);
    check("async_reset_flags", {62'd0, o_valid, o_busy}, 64'd0);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    do_op(32'd500, 32'd7, 1'b0, 32'd71, 32'd3, 34, 0);

    for (int t = 0; t < 150; t++) begin
      rs = 1'(t & 1);
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'($urandom_range(0, 15));
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 65535));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      ref_div(ra, rb, rs, rq, rr, rlat);
      do_op(ra, rb, rs, rq, rr, rlat, 0);
    end

    repeat (3) @(negedge i_clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
